// File: rtl/prbs7_checker_if.sv
// Bit-stream and status bundle between a PRBS7 source and its checker.
// The checker sits on the slave side: it consumes din/en/clr and reports lock, errors and counts.
interface prbs7_checker_if #(
  parameter int CNT_W = 16
);
  logic             din;
  logic             en;
  logic             clr;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output din, en, clr,
    input  locked, err, err_cnt, bit_cnt
  );

  modport slave (
    input  din, en, clr,
    output locked, err, err_cnt, bit_cnt
  );
endinterface

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) checker with saturating BER counters and windowed loss of lock.
// All outputs are registered; err pulses the cycle after the offending bit is sampled.
module prbs7_checker #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_ERR = 8,
  parameter int WINDOW     = 128,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  prbs7_checker_if.slave  bus
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [7:0]       LOCK_L   = 8'(LOCK_CNT);
  localparam logic [15:0]      UNLOCK_L = 16'(UNLOCK_ERR);
  localparam logic [15:0]      WINDOW_L = 16'(WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [6:0]       h_q, h_d;
  logic [2:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [15:0]      wbit_q, wbit_d;
  logic [15:0]      werr_q, werr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic             pred;
  logic             miss;
  logic [15:0]      wbit_inc;
  logic [15:0]      werr_inc;

  assign pred     = h_q[6] ^ h_q[5];
  assign miss     = bus.din ^ pred;
  assign wbit_inc = wbit_q + 16'd1;
  assign werr_inc = werr_q + {15'd0, miss};

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    fill_d    = fill_q;
    match_d   = match_q;
    wbit_d    = wbit_q;
    werr_d    = werr_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;

    if (bus.en) begin
      case (state_q)
        SEARCH: begin
          h_d = {h_q[5:0], bus.din};
          if (fill_q != 3'd7) begin
            fill_d = fill_q + 3'd1;
          end else if (miss) begin
            match_d = 8'd0;
          end else begin
            match_d = match_q + 8'd1;
          end
          // An all-zero history is a fixed point of the recurrence; never trust it.
          if (h_d == 7'd0) begin
            match_d = 8'd0;
          end
          if (match_d == LOCK_L) begin
            state_d = LOCKED;
          end
        end

        LOCKED: begin
          // Free-running reference: a flipped input bit never pollutes the history.
          h_d    = {h_q[5:0], pred};
          err_d  = miss;
          wbit_d = wbit_inc;
          werr_d = werr_inc;
          if (bit_cnt_q != CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
          if (miss && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
          end
          // An error on the window's last bit still belongs to that window.
          if (werr_inc == UNLOCK_L) begin
            state_d = SEARCH;
            fill_d  = 3'd0;
            match_d = 8'd0;
            wbit_d  = 16'd0;
            werr_d  = 16'd0;
          end else if (wbit_inc == WINDOW_L) begin
            wbit_d = 16'd0;
            werr_d = 16'd0;
          end
        end

        default: begin
          state_d = SEARCH;
        end
      endcase
    end

    if (bus.clr) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEARCH;
      h_q       <= 7'd0;
      fill_q    <= 3'd0;
      match_q   <= 8'd0;
      wbit_q    <= 16'd0;
      werr_q    <= 16'd0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      wbit_q    <= wbit_d;
      werr_q    <= werr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bus.locked  = (state_q == LOCKED);
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: two instances (16-bit and 4-bit counters) share one stimulus stream,
// checked every cycle against a sequence-level model plus hand-computed expectations.
module tb_prbs7_checker;

  localparam int LOCK_CNT   = 16;
  localparam int UNLOCK_ERR = 8;
  localparam int WINDOW     = 128;
  localparam logic [6:0] SEED = 7'h7F;

  logic clk;
  logic rst;
  logic din;
  logic en;
  logic clr;
  logic [6:0] gen_q;

  int n_cmp  = 0;
  int n_fail = 0;

  prbs7_checker_if #(.CNT_W(16)) bus_a ();
  prbs7_checker_if #(.CNT_W(4))  bus_b ();

  assign bus_a.din = din;
  assign bus_a.en  = en;
  assign bus_a.clr = clr;
  assign bus_b.din = din;
  assign bus_b.en  = en;
  assign bus_b.clr = clr;

  prbs7_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .WINDOW(WINDOW), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  prbs7_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .WINDOW(WINDOW), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- sequence-level model ----------------
  bit m_locked;
  bit m_err;
  int m_ecnt;
  int m_bcnt;
  int s_len;
  int wb;
  int we;
  bit g[$];

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_ecnt   = 0;
        m_bcnt   = 0;
        s_len    = 0;
        wb       = 0;
        we       = 0;
        g.delete();
        for (int i = 0; i < 7; i++) g.push_back(1'b0);
      end else begin
        m_err = 1'b0;
        if (en) begin
          if (!m_locked) begin
            g.push_back(din);
            s_len++;
            // Locked once the last LOCK_CNT bits all obey the recurrence on a non-zero history.
            if (s_len >= 7 + LOCK_CNT) begin
              bit ok;
              int n;
              ok = 1'b1;
              n  = g.size() - 1;
              for (int k = 0; k < LOCK_CNT; k++) begin
                int  j;
                bit  allz;
                j = n - k;
                if (g[j] != (g[j-6] ^ g[j-7])) ok = 1'b0;
                allz = 1'b1;
                for (int t = 0; t < 7; t++) if (g[j-t]) allz = 1'b0;
                if (allz) ok = 1'b0;
              end
              if (ok) m_locked = 1'b1;
            end
          end else begin
            bit p;
            int n;
            n = g.size() - 1;
            p = g[n-5] ^ g[n-6];
            g.push_back(p);
            m_err = (din != p);
            m_bcnt++;
            wb++;
            if (m_err) begin
              m_ecnt++;
              we++;
            end
            if (we == UNLOCK_ERR) begin
              m_locked = 1'b0;
              s_len    = 0;
              wb       = 0;
              we       = 0;
            end else if (wb == WINDOW) begin
              wb = 0;
              we = 0;
            end
          end
          while (g.size() > 64) void'(g.pop_front());
        end
        if (clr) begin
          m_ecnt = 0;
          m_bcnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("a_locked",  int'(bus_a.locked),  int'(m_locked));
    chk("a_err",     int'(bus_a.err),     int'(m_err));
    chk("a_err_cnt", int'(bus_a.err_cnt), sat(m_ecnt, 16));
    chk("a_bit_cnt", int'(bus_a.bit_cnt), sat(m_bcnt, 16));
    chk("b_locked",  int'(bus_b.locked),  int'(m_locked));
    chk("b_err",     int'(bus_b.err),     int'(m_err));
    chk("b_err_cnt", int'(bus_b.err_cnt), sat(m_ecnt, 4));
    chk("b_bit_cnt", int'(bus_b.bit_cnt), sat(m_bcnt, 4));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic d, input logic e, input logic c);
    din = d;
    en  = e;
    clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_gen(input logic flip, input logic e, input logic c);
    logic b;
    b = gen_q[6] ^ gen_q[5];
    if (e) gen_q = {gen_q[5:0], b};
    drive(b ^ flip, e, c);
  endtask

  task automatic reset_now(input string tag);
    #2 rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    #1;
    chk({tag, "_locked"},  int'(bus_a.locked),  0);
    chk({tag, "_err"},     int'(bus_a.err),     0);
    chk({tag, "_err_cnt"}, int'(bus_a.err_cnt), 0);
    chk({tag, "_bit_cnt"}, int'(bus_a.bit_cnt), 0);
    chk({tag, "_b_cnt"},   int'(bus_b.err_cnt), 0);
    @(negedge clk);
    rst   = 1'b0;
    gen_q = SEED;
  endtask

  initial begin
    int pulses;
    int nen;
    int nlk;
    bit lk_pre;
    logic e;

    rst = 1'b0;
    din = 1'b0;
    en  = 1'b0;
    clr = 1'b0;
    gen_q = SEED;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_locked",  int'(bus_a.locked),  0);
    chk("rst_err",     int'(bus_a.err),     0);
    chk("rst_err_cnt", int'(bus_a.err_cnt), 0);
    chk("rst_bit_cnt", int'(bus_a.bit_cnt), 0);
    rst = 1'b0;

    // Lock on a clean stream: 7 fill + 16 matches.
    for (int i = 0; i < 22; i++) send_gen(1'b0, 1'b1, 1'b0);
    chk("lock_bit22", int'(bus_a.locked), 0);
    send_gen(1'b0, 1'b1, 1'b0);
    chk("lock_bit23", int'(bus_a.locked), 1);

    for (int i = 0; i < 1000; i++) send_gen(1'b0, 1'b1, 1'b0);
    chk("clean_bit_cnt", int'(bus_a.bit_cnt), 1000);
    chk("clean_err_cnt", int'(bus_a.err_cnt), 0);
    chk("clean_b_bit_sat", int'(bus_b.bit_cnt), 15);

    // Three isolated errors, the last on the final bit of a window.
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      send_gen((i == 3 || i == 13 || i == 23) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      if (bus_a.err) pulses++;
    end
    chk("iso_pulses",  pulses, 3);
    chk("iso_err_cnt", int'(bus_a.err_cnt), 3);
    chk("iso_locked",  int'(bus_a.locked), 1);

    // Eight errors in a fresh window force loss of lock, then re-lock.
    send_gen(1'b0, 1'b0, 1'b1);
    chk("clr_idle_err_cnt", int'(bus_a.err_cnt), 0);
    for (int i = 0; i < 7; i++) send_gen(1'b1, 1'b1, 1'b0);
    chk("burst7_locked", int'(bus_a.locked), 1);
    send_gen(1'b1, 1'b1, 1'b0);
    chk("burst8_locked", int'(bus_a.locked), 0);
    chk("burst8_err",    int'(bus_a.err), 1);
    chk("burst8_err_cnt", int'(bus_a.err_cnt), 8);
    for (int i = 0; i < 22; i++) send_gen(1'b0, 1'b1, 1'b0);
    chk("relock_bit22", int'(bus_a.locked), 0);
    send_gen(1'b0, 1'b1, 1'b0);
    chk("relock_bit23", int'(bus_a.locked), 1);
    chk("relock_err_cnt", int'(bus_a.err_cnt), 8);
    for (int i = 0; i < 5; i++) send_gen(1'b0, 1'b1, 1'b0);

    reset_now("mid_rst");

    // Stuck-at-zero input must never lock.
    for (int i = 0; i < 500; i++) drive(1'b0, 1'b1, 1'b0);
    chk("zero_locked",  int'(bus_a.locked),  0);
    chk("zero_err_cnt", int'(bus_a.err_cnt), 0);
    chk("zero_bit_cnt", int'(bus_a.bit_cnt), 0);

    // Random en gaps on a clean stream.
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    gen_q = SEED;
    nen = 0;
    nlk = 0;
    for (int i = 0; i < 400; i++) begin
      e = 1'($urandom_range(0, 1));
      lk_pre = (nen >= 23);
      send_gen(1'b0, e, 1'b0);
      if (e) begin
        nen++;
        if (lk_pre) nlk++;
      end
      chk("rand_locked", int'(bus_a.locked), (nen >= 23) ? 1 : 0);
    end
    chk("rand_bit_cnt", int'(bus_a.bit_cnt), nlk);

    // Saturation of the 4-bit instance, then clr racing an error.
    send_gen(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      send_gen(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 19; i++) send_gen(1'b0, 1'b1, 1'b0);
    end
    chk("sat_b_err_cnt", int'(bus_b.err_cnt), 15);
    chk("sat_a_err_cnt", int'(bus_a.err_cnt), 20);
    chk("sat_locked",    int'(bus_a.locked), 1);
    send_gen(1'b1, 1'b1, 1'b1);
    chk("clrwin_a_err_cnt", int'(bus_a.err_cnt), 0);
    chk("clrwin_b_err_cnt", int'(bus_b.err_cnt), 0);
    chk("clrwin_a_bit_cnt", int'(bus_a.bit_cnt), 0);
    chk("clrwin_err",       int'(bus_a.err), 1);
    for (int i = 0; i < 10; i++) send_gen(1'b0, 1'b1, 1'b0);

    reset_now("end_rst");
    drive(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
